// File: rtl/sevseg_pkg.sv
// Shared seven-segment definitions: segment bit order {g,f,e,d,c,b,a}, active-high glyph codes.
package sevseg_pkg;

   localparam int unsigned SEG_W = 7;

   typedef logic [SEG_W-1:0] seg_code_t;

   // Bit positions inside a seg_code_t
   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;

   localparam seg_code_t SEG_0     = 7'h3F;
   localparam seg_code_t SEG_1     = 7'h06;
   localparam seg_code_t SEG_2     = 7'h5B;
   localparam seg_code_t SEG_3     = 7'h4F;
   localparam seg_code_t SEG_4     = 7'h66;
   localparam seg_code_t SEG_5     = 7'h6D;
   localparam seg_code_t SEG_6     = 7'h7D;
   localparam seg_code_t SEG_7     = 7'h07;
   localparam seg_code_t SEG_8     = 7'h7F;
   localparam seg_code_t SEG_9     = 7'h6F;
   localparam seg_code_t SEG_HEX_A = 7'h77;
   localparam seg_code_t SEG_HEX_B = 7'h7C;
   localparam seg_code_t SEG_HEX_C = 7'h39;
   localparam seg_code_t SEG_HEX_D = 7'h5E;
   localparam seg_code_t SEG_HEX_E = 7'h79;
   localparam seg_code_t SEG_HEX_F = 7'h71;

   // Active-low cathode pattern with every segment dark
   localparam seg_code_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/sevseg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment code.
module sevseg_hex_decode
   import sevseg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output seg_code_t  code_c
);

   always_comb begin
      code_c = SEG_0;
      case (nibble_i)
         4'h0: code_c = SEG_0;
         4'h1: code_c = SEG_1;
         4'h2: code_c = SEG_2;
         4'h3: code_c = SEG_3;
         4'h4: code_c = SEG_4;
         4'h5: code_c = SEG_5;
         4'h6: code_c = SEG_6;
         4'h7: code_c = SEG_7;
         4'h8: code_c = SEG_8;
         4'h9: code_c = SEG_9;
         4'hA: code_c = SEG_HEX_A;
         4'hB: code_c = SEG_HEX_B;
         4'hC: code_c = SEG_HEX_C;
         4'hD: code_c = SEG_HEX_D;
         4'hE: code_c = SEG_HEX_E;
         4'hF: code_c = SEG_HEX_F;
         default: code_c = SEG_0;
      endcase
   end

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment scan driver with per-frame input snapshot, blanking,
// leading-zero suppression and 8-level PWM brightness.
module sevseg_scan_ctrl
   import sevseg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned DIV_LOG2   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_suppress,
   input  logic [2:0]              bright,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic [SEG_W-1:0]        CAT,
   output logic                    DP,
   output logic                    frame_tick
);

   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned VAL_W = 4 * NUM_DIGITS;

   logic [DIV_LOG2-1:0]   pre_q, pre_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [VAL_W-1:0]      snap_val_q, snap_val_d;
   logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
   logic [NUM_DIGITS-1:0] snap_blank_q, snap_blank_d;
   logic                  snap_lz_q, snap_lz_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   seg_code_t             cat_q, cat_d;
   logic                  dp_q, dp_d;
   logic                  frame_tick_q, frame_tick_d;

   logic                  wrap_c, last_c, slot_on_c, zero_run_c;
   logic [NUM_DIGITS-1:0] sup_c;
   logic [3:0]            nib_c;
   logic                  dig_dp_c, dig_blank_c, dig_sup_c;
   seg_code_t             code_c;

   // Digit k is a leading zero when it and every more-significant snapshot nibble are zero
   always_comb begin
      sup_c      = '0;
      zero_run_c = snap_lz_q;
      for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
         zero_run_c = zero_run_c && (snap_val_q[4*k +: 4] == 4'h0);
         sup_c[k]   = zero_run_c;
      end
   end

   // Per-digit attributes for the digit currently being scanned
   always_comb begin
      nib_c       = '0;
      dig_dp_c    = 1'b0;
      dig_blank_c = 1'b0;
      dig_sup_c   = 1'b0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib_c       = snap_val_q[4*k +: 4];
            dig_dp_c    = snap_dp_q[k];
            dig_blank_c = snap_blank_q[k];
            dig_sup_c   = sup_c[k];
         end
      end
   end

   sevseg_hex_decode u_dec (
      .nibble_i (nib_c),
      .code_c   (code_c)
   );

   always_comb begin
      pre_d        = pre_q + DIV_LOG2'(1);
      idx_d        = idx_q;
      snap_val_d   = snap_val_q;
      snap_dp_d    = snap_dp_q;
      snap_blank_d = snap_blank_q;
      snap_lz_d    = snap_lz_q;
      frame_tick_d = 1'b0;
      an_d         = '1;
      cat_d        = SEG_BLANK;
      dp_d         = 1'b1;

      wrap_c    = &pre_q;
      last_c    = (idx_q == IDX_W'(NUM_DIGITS - 1));
      slot_on_c = (pre_q[DIV_LOG2-1 -: 3] <= bright);

      if (wrap_c) begin
         idx_d = last_c ? '0 : idx_q + IDX_W'(1);
      end

      // Tear-free capture at the end of the last digit slot
      if (wrap_c && last_c) begin
         snap_val_d   = value;
         snap_dp_d    = dp_in;
         snap_blank_d = blank_in;
         snap_lz_d    = lz_suppress;
         frame_tick_d = 1'b1;
      end

      if (slot_on_c && !dig_blank_c && !dig_sup_c) begin
         an_d  = ~(NUM_DIGITS'(1) << idx_q);
         cat_d = ~code_c;
         dp_d  = ~dig_dp_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q        <= '0;
         idx_q        <= '0;
         snap_val_q   <= '0;
         snap_dp_q    <= '0;
         snap_blank_q <= '0;
         snap_lz_q    <= 1'b0;
         an_q         <= '1;
         cat_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         pre_q        <= pre_d;
         idx_q        <= idx_d;
         snap_val_q   <= snap_val_d;
         snap_dp_q    <= snap_dp_d;
         snap_blank_q <= snap_blank_d;
         snap_lz_q    <= snap_lz_d;
         an_q         <= an_d;
         cat_q        <= cat_d;
         dp_q         <= dp_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign AN         = an_q;
   assign CAT        = cat_q;
   assign DP         = dp_q;
   assign frame_tick = frame_tick_q;

endmodule
